aqed_lb_fifo: RTL and testbench
===============================

# aqed_lb_fifo

Memory-core line buffer that sits on the far side of the A-QED monitor: it accepts the monitor's write stream (`wen_in`/`data_in`) and returns the stored words in order on `data_out`/`valid_out`. It also exports the `empty`/`full` status the monitor uses to gate issue and capture. Its accept rules and output timing are the exact contract the monitor's in-count/out-count bookkeeping depends on.

## Interface
- `DEPTH`, 128: entry count; power of 2, at least 4.
- `DATA_W`, 16: word width.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-low; clears all state on the edge where it is sampled low.
- `clk_en` input 1: global enable; when low, no state changes except reset.
- `flush` input 1: synchronous clear of buffer contents; overrides `wen_in` and `ren_in`.
- `wen_in` input 1: write request.
- `data_in` input DATA_W: write data.
- `ren_in` input 1: read request.
- `data_out` output DATA_W: read data, registered.
- `valid_out` output 1: one-cycle pulse, qualifies `data_out`.
- `empty` output 1: occupancy is 0.
- `full` output 1: occupancy is DEPTH.

## Operation
- Occupancy counter `count` is $clog2(DEPTH)+1 bits wide. Read and write pointers are $clog2(DEPTH) bits wide and wrap naturally modulo DEPTH.
- `empty` = (`count`==0). `full` = (`count`==DEPTH). Both are decoded from registered `count`, so they are glitch-free and have no comb path from the request inputs.
- Read accept: `rd_acc` = `clk_en` & `ren_in` & ~`empty` & ~`flush`.
- Write accept: `wr_acc` = `clk_en` & `wen_in` & ~`flush` & (~`full` | `rd_acc`).
- When full, a write is accepted only together with a read. This matches the monitor's issue rule: full & ren & wen is legal.
- Write to a full buffer with no read: the write is dropped and `count` is unchanged.
- Read from an empty buffer: no effect, and `valid_out` stays 0.
- No bypass. A word written while the buffer is empty cannot be read in the same cycle.
- `count` update: +1 on write-only, −1 on read-only, unchanged on both or neither.
- `flush` while `clk_en`:
  - Pointers and `count` go to 0.
  - `valid_out` goes to 0 on the next cycle.
  - `data_out` holds its value.
  - Memory contents are not cleared.
- `clk_en` low: everything freezes. `valid_out` holds its last value, and the monitor ignores it while `clk_en` is low.
- Reset values: `data_out`=0, `valid_out`=0, `empty`=1, `full`=0, pointers=0, `count`=0.
- Reset asserted mid-stream discards all stored words and any pending `valid_out`.

## Timing
- Read latency is 1. After `rd_acc` at edge N, `data_out` holds the oldest word and `valid_out`=1 after edge N+1.
- `valid_out` drops at the next enabled edge that has no `rd_acc`.
- Back-to-back reads produce a continuous `valid_out` stream, one word per cycle.
- Write visibility: `empty` deasserts the cycle after the first `wr_acc`. That word is readable from that cycle on.
- Throughput is 1 write plus 1 read per cycle, in any occupancy state except the dropped cases above.
- Priority: `reset` > `clk_en` gate > `flush` > read/write.

## Configuration
- Macro: `AQED_LB_ERR_EN`.
- Defined, the block adds:
  - Output `err` (1 bit): sticky flag, reset to 0 and cleared by `flush`.
  - `err` sets on an enabled cycle with `wen_in` & `full` & ~`ren_in` (overflow), or with `ren_in` & `empty` (underflow), when `flush` is low.
- Undefined: no `err` port and no added logic. The drop behaviour for overflow and underflow is identical in both builds.

## Structure
- Package `aqed_lb_pkg` holds:
  - Default constants `AQED_LB_DEPTH`=128 and `AQED_LB_DATA_W`=16.
  - Function `aqed_lb_ptr_w(depth)`, returning `$clog2(depth)`.
- Sub-module `aqed_lb_mem`: a 1R1W synchronous RAM, DEPTH×DATA_W.
  - The write port is enabled by `wr_acc`.
  - The registered read port is enabled by `rd_acc` and drives `data_out` directly.
  - Write-then-read to the same address in one cycle cannot occur, because there is no bypass.
- The top level holds the pointers, `count`, the flags, `valid_out` and the optional `err`.

## Test plan
- Reset, then write 0x0001..0x0004 on 4 consecutive cycles, then assert `ren_in` for 4 cycles → `data_out`=1,2,3,4 on cycles R+1..R+4 with `valid_out` high throughout; `empty`=1 afterwards.
- Fill with DEPTH writes → `full`=1. An extra write 0xBEEF without a read is dropped; a subsequent full drain returns exactly DEPTH words, and 0xBEEF never appears.
- Full plus simultaneous `wen_in`/`ren_in` with 0xAAAA → `full` stays 1, the oldest word is output, and 0xAAAA comes out last after 127 more reads.
- Write 3 words, then assert `flush` together with `ren_in` → `valid_out`=0 next cycle, `empty`=1, and a following read yields no `valid_out`.
- `clk_en` held low for 5 cycles mid-stream with `wen_in`/`ren_in` toggling → `count`, pointers and `data_out` are unchanged, and the stream resumes in order.
- With `AQED_LB_ERR_EN`: read while empty → `err`=1 and it stays 1 until `flush`, or until `reset` is sampled low.

Source files
------------

// File: rtl/aqed_lb_pkg.sv
// Shared constants and helpers for the A-QED line-buffer FIFO.
package aqed_lb_pkg;

   localparam int AQED_LB_DEPTH  = 128;
   localparam int AQED_LB_DATA_W = 16;

   function automatic int aqed_lb_ptr_w(input int depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/aqed_lb_fifo_if.sv
// Request/response bundle between the A-QED monitor (master) and the line buffer (slave).
// The sticky err flag exists only when AQED_LB_ERR_EN is defined.
interface aqed_lb_fifo_if
   import aqed_lb_pkg::*;
#(
   parameter int DATA_W = AQED_LB_DATA_W
);
   logic              clk_en;
   logic              flush;
   logic              wen_in;
   logic [DATA_W-1:0] data_in;
   logic              ren_in;
   logic [DATA_W-1:0] data_out;
   logic              valid_out;
   logic              empty;
   logic              full;
`ifdef AQED_LB_ERR_EN
   logic              err;
`endif

   modport master (
      output clk_en, flush, wen_in, data_in, ren_in,
`ifdef AQED_LB_ERR_EN
      input  err,
`endif
      input  data_out, valid_out, empty, full
   );

   modport slave (
      input  clk_en, flush, wen_in, data_in, ren_in,
`ifdef AQED_LB_ERR_EN
      output err,
`endif
      output data_out, valid_out, empty, full
   );
endinterface

// File: rtl/aqed_lb_mem.sv
// 1R1W synchronous RAM; the read register is the buffer's data_out (1-cycle latency,
// resets to 0, holds when rd_en is low). The array itself is never cleared.
module aqed_lb_mem
   import aqed_lb_pkg::*;
#(
   parameter int DEPTH  = AQED_LB_DEPTH,
   parameter int DATA_W = AQED_LB_DATA_W,
   parameter int PTR_W  = aqed_lb_ptr_w(DEPTH)
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [PTR_W-1:0]  wr_addr,
   input  logic [DATA_W-1:0] wr_dat,
   input  logic              rd_en,
   input  logic [PTR_W-1:0]  rd_addr,
   output logic [DATA_W-1:0] rd_dat
);
   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_dat;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         rd_dat <= '0;
      end else if (rd_en) begin
         rd_dat <= mem[rd_addr];
      end
   end
endmodule

// File: rtl/aqed_lb_fifo.sv
// In-order line buffer behind the A-QED monitor: 1-cycle registered read, full accepts a write
// only alongside a read. Optional sticky overflow/underflow flag under AQED_LB_ERR_EN.
module aqed_lb_fifo
   import aqed_lb_pkg::*;
#(
   parameter int DEPTH  = AQED_LB_DEPTH,
   parameter int DATA_W = AQED_LB_DATA_W
)(
   input  logic           clk,
   input  logic           reset,
   aqed_lb_fifo_if.slave  bus
);
   localparam int              PTR_W    = aqed_lb_ptr_w(DEPTH);
   localparam int              CNT_W    = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             empty;
   logic             full;
   logic             rd_acc;
   logic             wr_acc;
   logic             valid_q;

   // Flags decode registered count only, so no request input reaches them combinationally.
   assign empty = (count == '0);
   assign full  = (count == FULL_CNT);

   assign rd_acc = bus.clk_en & bus.ren_in & ~empty & ~bus.flush;
   assign wr_acc = bus.clk_en & bus.wen_in & ~bus.flush & (~full | rd_acc);

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         valid_q <= 1'b0;
      end else if (bus.clk_en) begin
         valid_q <= rd_acc;
         if (bus.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (wr_acc) wr_ptr <= wr_ptr + PTR_W'(1);
            if (rd_acc) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({wr_acc, rd_acc})
               2'b10:   count <= count + CNT_W'(1);
               2'b01:   count <= count - CNT_W'(1);
               default: count <= count;
            endcase
         end
      end
   end

   aqed_lb_mem #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W),
      .PTR_W  (PTR_W)
   ) u_mem (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr_acc),
      .wr_addr (wr_ptr),
      .wr_dat  (bus.data_in),
      .rd_en   (rd_acc),
      .rd_addr (rd_ptr),
      .rd_dat  (bus.data_out)
   );

   assign bus.valid_out = valid_q;
   assign bus.empty     = empty;
   assign bus.full      = full;

`ifdef AQED_LB_ERR_EN
   logic err_q;

   // Flags the request, not the accept: a dropped overflow write or underflow read still sets it.
   always_ff @(posedge clk) begin
      if (!reset) begin
         err_q <= 1'b0;
      end else if (bus.clk_en) begin
         if (bus.flush) begin
            err_q <= 1'b0;
         end else if ((bus.wen_in & full & ~bus.ren_in) | (bus.ren_in & empty)) begin
            err_q <= 1'b1;
         end
      end
   end

   assign bus.err = err_q;
`endif
endmodule

// File: tb/tb_aqed_lb_fifo.sv
// Scoreboard bench for aqed_lb_fifo: queue model of buffer contents, expected read words
// queued at drive time and compared when valid_out appears.
module tb_aqed_lb_fifo;
   import aqed_lb_pkg::*;

   localparam int DEPTH  = 128;
   localparam int DATA_W = 16;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   aqed_lb_fifo_if #(.DATA_W(DATA_W)) bus ();

   aqed_lb_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_chk = 0;
   int n_err = 0;

   logic [DATA_W-1:0] mq[$];
   logic [DATA_W-1:0] outq[$];
   logic [DATA_W-1:0] exp_data;
   logic              exp_valid;
   logic              exp_err;
   logic              seen_beef;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_flags();
      chk("empty", {31'd0, bus.empty}, {31'd0, mq.size() == 0});
      chk("full",  {31'd0, bus.full},  {31'd0, mq.size() == DEPTH});
`ifdef AQED_LB_ERR_EN
      chk("err", {31'd0, bus.err}, {31'd0, exp_err});
`endif
   endtask

   task automatic do_reset();
      // Requests stay asserted through reset to show reset overrides them.
      reset       = 1'b0;
      bus.clk_en  = 1'b1;
      bus.flush   = 1'b0;
      bus.wen_in  = 1'b1;
      bus.ren_in  = 1'b1;
      bus.data_in = 16'h5555;
      @(posedge clk);
      #1;
      reset = 1'b1;
      mq.delete();
      outq.delete();
      exp_data  = '0;
      exp_valid = 1'b0;
      exp_err   = 1'b0;
      chk("rst_valid", {31'd0, bus.valid_out}, 32'd0);
      chk("rst_data",  {16'd0, bus.data_out},  32'd0);
      check_flags();
   endtask

   task automatic step(input logic en, input logic fl, input logic w,
                       input logic [DATA_W-1:0] d, input logic r);
      logic rd, wr, was_empty, was_full;
      logic [DATA_W-1:0] word;
      was_empty = (mq.size() == 0);
      was_full  = (mq.size() == DEPTH);
      rd = en & r & ~was_empty & ~fl;
      wr = en & w & ~fl & (~was_full | rd);
      bus.clk_en  = en;
      bus.flush   = fl;
      bus.wen_in  = w;
      bus.data_in = d;
      bus.ren_in  = r;
      if (rd) begin
         word = mq.pop_front();
         outq.push_back(word);
         exp_data = word;
      end
      if (wr) mq.push_back(d);
      if (en & fl) mq.delete();
      if (en) exp_valid = rd;
      if (en) begin
         if (fl) exp_err = 1'b0;
         else if ((w & was_full & ~r) | (r & was_empty)) exp_err = 1'b1;
      end
      @(posedge clk);
      #1;
      chk("valid", {31'd0, bus.valid_out}, {31'd0, exp_valid});
      if (en && bus.valid_out) begin
         if (outq.size() > 0) chk("rd_word", {16'd0, bus.data_out}, {16'd0, outq.pop_front()});
         else chk("spurious_valid", 32'd1, 32'd0);
         if (bus.data_out == 16'hBEEF) seen_beef = 1'b1;
      end
      chk("data_out", {16'd0, bus.data_out}, {16'd0, exp_data});
      check_flags();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      seen_beef = 1'b0;
      do_reset();
      do_reset();

      // Basic in-order write then continuous read stream
      for (int i = 1; i <= 4; i++) step(1, 0, 1, DATA_W'(i), 0);
      for (int i = 0; i < 4; i++) step(1, 0, 0, '0, 1);
      step(1, 0, 0, '0, 0);
      // No bypass: write+read while empty gives no read
      step(1, 0, 1, 16'h0077, 1);
      step(1, 0, 0, '0, 1);
      step(1, 0, 0, '0, 1);

      // Fill, drop overflow, full write+read, drain
      for (int i = 0; i < DEPTH; i++) step(1, 0, 1, DATA_W'(16'h1000 + i), 0);
      chk("fill_full", {31'd0, bus.full}, 32'd1);
      step(1, 0, 1, 16'hBEEF, 0);
      step(1, 0, 1, 16'hAAAA, 1);
      chk("rw_full_stays", {31'd0, bus.full}, 32'd1);
      for (int i = 0; i < DEPTH; i++) step(1, 0, 0, '0, 1);
      chk("drain_last", {16'd0, bus.data_out}, 32'h0000AAAA);
      step(1, 0, 0, '0, 1);
      chk("no_beef", {31'd0, seen_beef}, 32'd0);

      // Flush with a pending read
      for (int i = 0; i < 3; i++) step(1, 0, 1, DATA_W'(16'h2000 + i), 0);
      step(1, 0, 0, '0, 1);
      step(1, 1, 0, '0, 1);
      step(1, 0, 0, '0, 1);
      step(1, 0, 1, 16'h2100, 0);
      step(1, 0, 0, '0, 1);

      // Clock-enable freeze mid-stream
      for (int i = 0; i < 6; i++) step(1, 0, 1, DATA_W'(16'h3000 + i), 0);
      step(1, 0, 0, '0, 1);
      step(1, 0, 1, 16'h3100, 1);
      for (int i = 0; i < 5; i++) step(0, i[0], ~i[0], 16'hDEAD, i[0]);
      for (int i = 0; i < 7; i++) step(1, 0, 0, '0, 1);

      // Random mixed traffic
      for (int i = 0; i < 400; i++)
         step($urandom_range(0, 9) != 0, $urandom_range(0, 29) == 0,
              $urandom_range(0, 1) == 1, DATA_W'($urandom), $urandom_range(0, 1) == 1);

      // Reset mid-stream with a pending read
      for (int i = 0; i < 5; i++) step(1, 0, 1, DATA_W'(16'h4000 + i), 0);
      step(1, 0, 0, '0, 1);
      do_reset();
      step(1, 0, 0, '0, 1);
      step(1, 0, 1, 16'h4444, 0);
      step(1, 0, 0, '0, 1);

      chk("sb_drained", outq.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
